// File: rtl/vcs_pkg.sv
// Shared types for the vector control sequencer:
// opcodes, ALU encodings and the control word bundle.
package vcs_pkg;

  localparam logic [4:0] OP_R  = 5'b01100;
  localparam logic [4:0] OP_I  = 5'b00100;
  localparam logic [4:0] OP_LD = 5'b00000;
  localparam logic [4:0] OP_ST = 5'b01000;
  localparam logic [4:0] OP_BR = 5'b11000;
  localparam logic [4:0] OP_V  = 5'b10101;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_FN  = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluctl_e;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic       resultsrc;
    logic       branch;
    logic       vectorial;
    logic       illegal;
    logic [1:0] immsrc;
    logic [2:0] aluctl;
  } ctrl_word_t;

  typedef enum logic {
    S_IDLE,
    S_VECTOR
  } state_e;

endpackage

// File: rtl/vcs_decode.sv
// Combinational main + ALU decode into a control word.
// Bad funct3 on an ALUOp=10 op turns into an illegal, non-writing word.
module vcs_decode
  import vcs_pkg::*;
(
  input  logic [4:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_word_t cw
);

  aluop_e aluop;
  logic   rtype;
  logic   unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    cw    = '0;
    aluop = ALUOP_ADD;
    rtype = 1'b0;
    unique case (1'b1)
      (Op == OP_R): begin
        cw.regwrite = 1'b1;
        aluop       = ALUOP_FN;
        rtype       = 1'b1;
      end
      (Op == OP_I): begin
        cw.regwrite = 1'b1;
        cw.alusrc   = 1'b1;
        aluop       = ALUOP_FN;
      end
      (Op == OP_LD): begin
        cw.regwrite  = 1'b1;
        cw.alusrc    = 1'b1;
        cw.resultsrc = 1'b1;
      end
      (Op == OP_ST): begin
        cw.memwrite = 1'b1;
        cw.alusrc   = 1'b1;
        cw.immsrc   = 2'b01;
      end
      (Op == OP_BR): begin
        cw.branch = 1'b1;
        cw.immsrc = 2'b10;
        aluop     = ALUOP_SUB;
      end
      (Op == OP_V): begin
        cw.regwrite  = 1'b1;
        cw.vectorial = 1'b1;
        aluop        = ALUOP_FN;
        rtype        = 1'b1;
      end
      default: cw.illegal = 1'b1;
    endcase

    unique case (aluop)
      ALUOP_ADD: cw.aluctl = ALU_ADD;
      ALUOP_SUB: cw.aluctl = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000:
            cw.aluctl = (funct7[5] && rtype)
                      ? ALU_SUB : ALU_ADD;
          3'b010: cw.aluctl = ALU_SLT;
          3'b110: cw.aluctl = ALU_OR;
          3'b111: cw.aluctl = ALU_AND;
          default: begin
            cw.illegal  = 1'b1;
            cw.regwrite = 1'b0;
            cw.memwrite = 1'b0;
            cw.aluctl   = ALU_ADD;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Registered control word with vector beat sequencing.
// Vector ops hold off fetch until their last beat is consumed.
module vector_control_sequencer
  import vcs_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VLEN_MAX  = 16,
  localparam int VW = $clog2(VLEN_MAX + 1),
  localparam int EW = (VLEN_MAX > 1)
                    ? $clog2(VLEN_MAX) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           Op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [VW-1:0]        vl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic                 ResultSrc,
  output logic                 Branch,
  output logic                 vectorial,
  output logic                 illegal,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic [EW-1:0]        elem_base,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic                 last,
  output logic                 busy
);

  localparam logic [VW-1:0] VMAX = VW'(VLEN_MAX);
  localparam logic [VW-1:0] NL   = VW'(NUM_LANES);

  function automatic logic [NUM_LANES-1:0]
    mask_of(input logic [VW-1:0] b,
            input logic [VW-1:0] n);
    logic [NUM_LANES-1:0] m;
    for (int i = 0; i < NUM_LANES; i++)
      m[i] = (32'(b) + 32'(i)) < 32'(n);
    return m;
  endfunction

  function automatic logic
    last_of(input logic [VW-1:0] b,
            input logic [VW-1:0] n);
    return (32'(b) + 32'(NUM_LANES)) >= 32'(n);
  endfunction

  state_e               state, state_nxt;
  ctrl_word_t           dec, cw_q;
  logic [VW-1:0]        vl_in_eff, vl_eff_q, base_nxt;
  logic [EW-1:0]        base_q;
  logic [NUM_LANES-1:0] mask_q;
  logic                 last_q, valid_q, rdy_en;
  logic                 accept, fire, vec_in;

  vcs_decode u_dec (
    .Op     (Op),
    .funct3 (funct3),
    .funct7 (funct7),
    .cw     (dec)
  );

  assign vec_in    = dec.vectorial && !dec.illegal;
  assign vl_in_eff = (vl > VMAX) ? VMAX : vl;
  assign base_nxt  = VW'(base_q) + NL;
  assign accept    = in_valid && in_ready;
  assign fire      = valid_q && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept && vec_in && (vl_in_eff > NL))
          state_nxt = S_VECTOR;
      S_VECTOR:
        if (fire && last_q)
          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    in_ready = rdy_en && (state == S_IDLE)
            && (!valid_q || out_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en   <= 1'b0;
      valid_q  <= 1'b0;
      cw_q     <= '0;
      vl_eff_q <= '0;
      base_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        valid_q <= 1'b1;
        cw_q    <= dec;
        base_q  <= '0;
        mask_q  <= '1;
        last_q  <= 1'b1;
        if (vec_in) begin
          vl_eff_q <= vl_in_eff;
          mask_q   <= mask_of('0, vl_in_eff);
          last_q   <= last_of('0, vl_in_eff);
          if (vl_in_eff == '0)
            cw_q.regwrite <= 1'b0;
        end
      end else if (fire && (state == S_VECTOR)
                   && !last_q) begin
        base_q <= EW'(base_nxt);
        mask_q <= mask_of(base_nxt, vl_eff_q);
        last_q <= last_of(base_nxt, vl_eff_q);
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign RegWrite   = cw_q.regwrite;
  assign ALUSrc     = cw_q.alusrc;
  assign MemWrite   = cw_q.memwrite;
  assign ResultSrc  = cw_q.resultsrc;
  assign Branch     = cw_q.branch;
  assign vectorial  = cw_q.vectorial;
  assign illegal    = cw_q.illegal;
  assign ImmSrc     = cw_q.immsrc;
  assign ALUControl = cw_q.aluctl;
  assign elem_base  = base_q;
  assign lane_mask  = mask_q;
  assign last       = last_q;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Scoreboard bench: expected beats queued at issue,
// a monitor pops and compares on every output handshake.
module tb_vector_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [4:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] vl;
  logic       out_valid, out_ready;
  logic       RegWrite, ALUSrc, MemWrite, ResultSrc;
  logic       Branch, vectorial, illegal;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] elem_base;
  logic [3:0] lane_mask;
  logic       last, busy;

  vector_control_sequencer #(
    .NUM_LANES (4),
    .VLEN_MAX  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Op         (Op),
    .funct3     (funct3),
    .funct7     (funct7),
    .vl         (vl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemWrite   (MemWrite),
    .ResultSrc  (ResultSrc),
    .Branch     (Branch),
    .vectorial  (vectorial),
    .illegal    (illegal),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .elem_base  (elem_base),
    .lane_mask  (lane_mask),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cw;
    logic [3:0]  base;
    logic [3:0]  mask;
    logic        lst;
    logic        rdy;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  // {RegWrite,ALUSrc,MemWrite,ResultSrc,Branch,vectorial,illegal,ImmSrc,ALUControl}
  localparam logic [11:0] R_SUB = 12'b1000000_00_001;
  localparam logic [11:0] R_OR  = 12'b1000000_00_011;
  localparam logic [11:0] R_AND = 12'b1000000_00_010;
  localparam logic [11:0] R_SLT = 12'b1000000_00_101;
  localparam logic [11:0] ILL   = 12'b0000001_00_000;
  localparam logic [11:0] I_ADD = 12'b1100000_00_000;
  localparam logic [11:0] LD    = 12'b1101000_00_000;
  localparam logic [11:0] ST    = 12'b0110000_01_000;
  localparam logic [11:0] BR    = 12'b0000100_10_001;
  localparam logic [11:0] V_ADD = 12'b1000010_00_000;
  localparam logic [11:0] V_SUB = 12'b1000010_00_001;
  localparam logic [11:0] V_0   = 12'b0000010_00_000;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endfunction

  task automatic push(logic [11:0] cw, logic [3:0] b,
                      logic [3:0] m, logic l, logic r);
    beat_t e;
    e.cw = cw; e.base = b; e.mask = m;
    e.lst = l; e.rdy = r;
    sb.push_back(e);
  endtask

  task automatic push1(logic [11:0] cw);
    push(cw, 4'd0, 4'b1111, 1'b1, 1'b1);
  endtask

  task automatic send(logic [4:0] o, logic [2:0] f3,
                      logic [6:0] f7, logic [4:0] v);
    int n = 0;
    @(negedge clk);
    Op = o; funct3 = f3; funct7 = f7; vl = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Samples just before each rising edge, away from input changes.
  always @(negedge clk) begin
    beat_t e;
    #4;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_beat: got base=%0d want none",
                 elem_base);
      end else begin
        e = sb.pop_front();
        chk("ctrl", 32'({RegWrite, ALUSrc, MemWrite,
            ResultSrc, Branch, vectorial, illegal,
            ImmSrc, ALUControl}), 32'(e.cw));
        chk("elem_base", 32'(elem_base), 32'(e.base));
        chk("lane_mask", 32'(lane_mask), 32'(e.mask));
        chk("last", 32'(last), 32'(e.lst));
        chk("in_ready", 32'(in_ready), 32'(e.rdy));
      end
    end
  end

  function automatic logic [23:0] all_out();
    return {out_valid, RegWrite, ALUSrc, MemWrite,
            ResultSrc, Branch, vectorial, illegal,
            ImmSrc, ALUControl, elem_base, lane_mask,
            last, busy, in_ready};
  endfunction

  localparam logic [6:0] F7S = 7'b0100000;
  localparam logic [4:0] OPR = 5'b01100;
  localparam logic [4:0] OPV = 5'b10101;

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Op = '0; funct3 = '0; funct7 = '0; vl = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", 32'(all_out()), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("reset_release_rdy", 32'(in_ready), 32'd1);

    // scalar decode, back to back
    push1(R_SUB); send(OPR, 3'b000, F7S, 5'd0);
    push1(R_OR);  send(OPR, 3'b110, 7'd0, 5'd0);
    push1(R_AND); send(OPR, 3'b111, 7'd0, 5'd0);
    push1(R_SLT); send(OPR, 3'b010, 7'd0, 5'd0);
    push1(ILL);   send(OPR, 3'b001, 7'd0, 5'd0);
    push1(I_ADD); send(5'b00100, 3'b000, F7S, 5'd0);
    push1(LD);    send(5'b00000, 3'b010, 7'd0, 5'd0);
    push1(ST);    send(5'b01000, 3'b010, 7'd0, 5'd0);
    push1(BR);    send(5'b11000, 3'b000, 7'd0, 5'd0);
    push1(ILL);   send(5'b11111, 3'b000, 7'd0, 5'd0);

    // vl=10
    push(V_ADD, 4'd0, 4'b1111, 1'b0, 1'b0);
    push(V_ADD, 4'd4, 4'b1111, 1'b0, 1'b0);
    push(V_ADD, 4'd8, 4'b0011, 1'b1, 1'b0);
    send(OPV, 3'b000, 7'd0, 5'd10);

    // vl=20 clamps to 16
    push(V_SUB, 4'd0,  4'b1111, 1'b0, 1'b0);
    push(V_SUB, 4'd4,  4'b1111, 1'b0, 1'b0);
    push(V_SUB, 4'd8,  4'b1111, 1'b0, 1'b0);
    push(V_SUB, 4'd12, 4'b1111, 1'b1, 1'b0);
    send(OPV, 3'b000, F7S, 5'd20);

    // vl=0 and a short single-beat vector
    push(V_0, 4'd0, 4'b0000, 1'b1, 1'b1);
    send(OPV, 3'b000, 7'd0, 5'd0);
    push(V_ADD, 4'd0, 4'b0111, 1'b1, 1'b1);
    send(OPV, 3'b000, 7'd0, 5'd3);

    // back-pressure on beat 2
    push(V_ADD, 4'd0, 4'b1111, 1'b0, 1'b0);
    push(V_ADD, 4'd4, 4'b1111, 1'b0, 1'b0);
    push(V_ADD, 4'd8, 4'b0011, 1'b1, 1'b0);
    send(OPV, 3'b000, 7'd0, 5'd10);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold", 32'({out_valid, elem_base,
          lane_mask, last, in_ready}),
          32'({1'b1, 4'd4, 4'b1111, 1'b0, 1'b0}));
    end
    @(negedge clk) out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain1", 32'(sb.size()), 32'd0);

    // reset in the middle of a vector
    push(V_ADD, 4'd0, 4'b1111, 1'b0, 1'b0);
    send(OPV, 3'b000, 7'd0, 5'd16);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("midreset_outs", 32'(all_out()), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("midreset_rdy", 32'(in_ready), 32'd1);

    push1(R_SUB); send(OPR, 3'b000, F7S, 5'd0);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("drain2", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
